// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: opcode/ALU-op constants, bypass select encodings and hazard FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a. Shared by fwd_hazard_unit, fwd_select and the interface users.
package fwd_hazard_unit_pkg;

  // Major opcodes, instruction bits [31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  // R-type ALU sub-ops, instruction bits [6:2]
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Operand bypass mux encodings
  localparam logic [1:0] BYP_XM   = 2'b00;
  localparam logic [1:0] BYP_MW   = 2'b01;
  localparam logic [1:0] BYP_RF   = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MD_WAIT    = 2'd2
  } hz_state_e;

  // Opcodes that write the register file (rd / valid qualification is done by the caller)
  function automatic logic is_writer_op(input logic [4:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-latch IRs, valids and multdiv ready in; bypass/stall/multdiv controls out.
// Latency: n/a (wiring only). slave = hazard unit, master = pipeline / testbench.
// Backpressure: none; with FWD_HAZARD_PERF_EN defined, carries stall_cycle_count and bypass_hit_count.
interface fwd_hazard_unit_if #(
  parameter int INSTR_W = 32
);
  logic [INSTR_W-1:0] decode_instruction;
  logic [INSTR_W-1:0] execute_instruction;
  logic [INSTR_W-1:0] memory_instruction;
  logic [INSTR_W-1:0] write_instruction;
  logic               memory_valid;
  logic               write_valid;
  logic               muldiv_result_ready;

  logic [1:0]         bypass_A_mux_selector;
  logic [1:0]         bypass_B_mux_selector;
  logic               bypass_ram_en;
  logic               stall_front;
  logic               stall_execute;
  logic               insert_bubble;
  logic               muldiv_start;
  logic               muldiv_error;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]        stall_cycle_count;
  logic [31:0]        bypass_hit_count;
`endif

  modport slave (
    input  decode_instruction, execute_instruction, memory_instruction, write_instruction,
    input  memory_valid, write_valid, muldiv_result_ready,
    output bypass_A_mux_selector, bypass_B_mux_selector, bypass_ram_en,
    output stall_front, stall_execute, insert_bubble, muldiv_start, muldiv_error
`ifdef FWD_HAZARD_PERF_EN
    , output stall_cycle_count, bypass_hit_count
`endif
  );

  modport master (
    output decode_instruction, execute_instruction, memory_instruction, write_instruction,
    output memory_valid, write_valid, muldiv_result_ready,
    input  bypass_A_mux_selector, bypass_B_mux_selector, bypass_ram_en,
    input  stall_front, stall_execute, insert_bubble, muldiv_start, muldiv_error
`ifdef FWD_HAZARD_PERF_EN
    , input stall_cycle_count, bypass_hit_count
`endif
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// fwd_select: priority bypass select for one ALU operand (X/M over M/W over regfile).
// Latency: 0 cycles, purely combinational. Ports: src_addr_i, xm/mw rd + writer flags in; sel_o out.
// Backpressure: none. Writer flags must already exclude r0 and invalid stages.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] xm_rd_i,
  input  logic              xm_wr_i,
  input  logic [ADDR_W-1:0] mw_rd_i,
  input  logic              mw_wr_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = BYP_RF;
    if (xm_wr_i && (xm_rd_i == src_addr_i)) begin
      sel_o = BYP_XM;
    end else if (mw_wr_i && (mw_rd_i == src_addr_i)) begin
      sel_o = BYP_MW;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand/store-data bypass selects plus load-use stall and multdiv wait FSM.
// Latency: bypass selects, load-use stall/bubble are 0-cycle; muldiv_start/muldiv_error registered.
// Backpressure: stall_front/stall_execute freeze the pipe while the multdiv unit is busy.
// Ports: clock, reset_n (async, active-low), bus (fwd_hazard_unit_if.slave).
// Optional macro FWD_HAZARD_PERF_EN adds saturating stall_cycle_count / bypass_hit_count.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int INSTR_W        = 32,
  parameter int ADDR_W         = 5,
  parameter int MULDIV_TIMEOUT = 40,  // >= 2
  parameter int CNT_W          = 6    // 2**CNT_W > MULDIV_TIMEOUT
) (
  input logic              clock,
  input logic              reset_n,
  fwd_hazard_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_TIMEOUT - 1);

  logic [INSTR_W-1:0] fd_ir, dx_ir, xm_ir, mw_ir;
  assign fd_ir = bus.decode_instruction;
  assign dx_ir = bus.execute_instruction;
  assign xm_ir = bus.memory_instruction;
  assign mw_ir = bus.write_instruction;

  logic [4:0]        fd_op, dx_op, xm_op, mw_op, dx_aluop;
  logic [ADDR_W-1:0] fd_rd, fd_rs, fd_rt, dx_rd, dx_rs, dx_rt, xm_rd, mw_rd;

  assign fd_op    = fd_ir[31:27];
  assign dx_op    = dx_ir[31:27];
  assign xm_op    = xm_ir[31:27];
  assign mw_op    = mw_ir[31:27];
  assign dx_aluop = dx_ir[6:2];
  assign fd_rd    = fd_ir[22 +: ADDR_W];
  assign fd_rs    = fd_ir[17 +: ADDR_W];
  assign fd_rt    = fd_ir[12 +: ADDR_W];
  assign dx_rd    = dx_ir[22 +: ADDR_W];
  assign dx_rs    = dx_ir[17 +: ADDR_W];
  assign dx_rt    = dx_ir[12 +: ADDR_W];
  assign xm_rd    = xm_ir[22 +: ADDR_W];
  assign mw_rd    = mw_ir[22 +: ADDR_W];

  logic unused_ir_bits;
  assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[11:7], dx_ir[1:0], xm_ir[21:0], mw_ir[21:0]};

  // r0 is hardwired zero, so a write to it must never be forwarded
  logic xm_wr, mw_wr;
  assign xm_wr = bus.memory_valid && is_writer_op(xm_op) && (xm_rd != '0);
  assign mw_wr = bus.write_valid  && is_writer_op(mw_op) && (mw_rd != '0);

  logic [1:0] sel_a, sel_b;

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_a (
    .src_addr_i (dx_rs),
    .xm_rd_i    (xm_rd),
    .xm_wr_i    (xm_wr),
    .mw_rd_i    (mw_rd),
    .mw_wr_i    (mw_wr),
    .sel_o      (sel_a)
  );

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_b (
    .src_addr_i (dx_rt),
    .xm_rd_i    (xm_rd),
    .xm_wr_i    (xm_wr),
    .mw_rd_i    (mw_rd),
    .mw_wr_i    (mw_wr),
    .sel_o      (sel_b)
  );

  assign bus.bypass_A_mux_selector = sel_a;
  assign bus.bypass_B_mux_selector = sel_b;
  // Store in X/M needs the value M/W is about to write back
  assign bus.bypass_ram_en = (xm_op == OP_SW) && mw_wr && (xm_rd == mw_rd);

  // Which register fields the instruction in decode actually reads
  logic fd_reads_rt, fd_reads_rd, load_use, md_req;
  assign fd_reads_rt = (fd_op == OP_RTYPE);
  assign fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                       (fd_op == OP_BLT) || (fd_op == OP_JR);
  assign load_use = (dx_op == OP_LW) && (dx_rd != '0) &&
                    ((dx_rd == fd_rs) ||
                     (fd_reads_rt && (dx_rd == fd_rt)) ||
                     (fd_reads_rd && (dx_rd == fd_rd)));
  assign md_req = (dx_op == OP_RTYPE) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

  hz_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q, error_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // multdiv checked first; muldiv_result_ready is ignored here
          if (md_req) begin
            state_q <= MD_WAIT;
            cnt_q   <= '0;
            start_q <= 1'b1;
          end else if (load_use) begin
            state_q <= LOAD_STALL;
          end
        end
        // The bubble has replaced the lw in D/X, so no hazard check here
        LOAD_STALL: state_q <= IDLE;
        MD_WAIT: begin
          // ready takes precedence over a timeout in the same cycle
          if (bus.muldiv_result_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic lu_stall, stall_front_w;
  assign lu_stall      = (state_q == IDLE) && !md_req && load_use;
  assign stall_front_w = (state_q == MD_WAIT) || lu_stall;

  assign bus.stall_front   = stall_front_w;
  assign bus.stall_execute = (state_q == MD_WAIT);
  assign bus.insert_bubble = lu_stall;
  assign bus.muldiv_start  = start_q;
  assign bus.muldiv_error  = error_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, hit_cnt_q, hit_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    if (stall_front_w && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (((sel_a != BYP_RF) || (sel_b != BYP_RF)) && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign bus.stall_cycle_count = stall_cnt_q;
  assign bus.bypass_hit_count  = hit_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed, scoreboard-based bench for fwd_hazard_unit.
// Inputs driven 1 time unit after the rising edge; outputs sampled 3 units after it.
// With FWD_HAZARD_PERF_EN defined, the performance counters are checked as well.
module tb_fwd_hazard_unit;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  fwd_hazard_unit_if #(.INSTR_W(32)) bus ();

  fwd_hazard_unit #(
    .INSTR_W        (32),
    .ADDR_W         (5),
    .MULDIV_TIMEOUT (40),
    .CNT_W          (6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_hits  = 0;
`endif

  localparam logic [4:0] R = 5'b00000, ADDI = 5'b00101, LW = 5'b01000, SW = 5'b00111, BNE = 5'b00010;
  localparam logic [4:0] MUL = 5'b00110, DIV = 5'b00111;

  function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  // Packed expectation: {selA, selB, ram_en, stall_front, stall_execute, bubble, start, error}
  function automatic logic [9:0] ex(input logic [1:0] a, b, input logic ram, sf, se, ib, st, er);
    return {a, b, ram, sf, se, ib, st, er};
  endfunction

  function automatic logic [9:0] observed();
    return {bus.bypass_A_mux_selector, bus.bypass_B_mux_selector, bus.bypass_ram_en,
            bus.stall_front, bus.stall_execute, bus.insert_bubble, bus.muldiv_start, bus.muldiv_error};
  endfunction

  task automatic check_out();
    sb_t        e;
    logic [9:0] o;
    o = observed();
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_underflow observed=%b", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%b expected=%b (A B ram sf se ib st er)", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic sample(input string tag, input logic [9:0] exp);
    sb.push_back('{tag, exp});
    #1;
    check_out();
  endtask

  // One clock cycle: drive at edge+1, check at edge+3, advance to next edge+1
  task automatic step(input string tag, input logic [31:0] fd, dx, xm, mw,
                      input logic mv, wv, rdy, input logic [9:0] exp);
    bus.decode_instruction  = fd;
    bus.execute_instruction = dx;
    bus.memory_instruction  = xm;
    bus.write_instruction   = mw;
    bus.memory_valid        = mv;
    bus.write_valid         = wv;
    bus.muldiv_result_ready = rdy;
    #1;
    sample(tag, exp);
`ifdef FWD_HAZARD_PERF_EN
    if (exp[9:8] != 2'b10 || exp[7:6] != 2'b10) exp_hits++;
    if (exp[5]) exp_stall = exp_stall;
    if (exp[4]) exp_stall++;
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag, input logic rdy, input logic err);
    step(tag, 0, 0, 0, 0, 1'b0, 1'b0, rdy, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, err));
  endtask

`ifdef FWD_HAZARD_PERF_EN
  task automatic check_perf(input string tag);
    n_cmp += 2;
    assert (bus.stall_cycle_count === exp_stall) else begin
      n_err++;
      $error("FAIL %s_stall_cnt observed=%0d expected=%0d", tag, bus.stall_cycle_count, exp_stall);
    end
    assert (bus.bypass_hit_count === exp_hits) else begin
      n_err++;
      $error("FAIL %s_hit_cnt observed=%0d expected=%0d", tag, bus.bypass_hit_count, exp_hits);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n                 = 1'b0;
    bus.decode_instruction  = '0;
    bus.execute_instruction = '0;
    bus.memory_instruction  = '0;
    bus.write_instruction   = '0;
    bus.memory_valid        = 1'b0;
    bus.write_valid         = 1'b0;
    bus.muldiv_result_ready = 1'b0;
    #2;
    sample("reset_state", ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
`ifdef FWD_HAZARD_PERF_EN
    check_perf("reset");
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ---------------- forwarding ----------------
    step("fwd_both_xm", 0, ins(R, 1, 5, 5, 0), ins(R, 5, 0, 0, 0), ins(ADDI, 5, 0, 0, 0), 1, 1, 0,
         ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step("fwd_xm_inval", 0, ins(R, 1, 5, 5, 0), ins(R, 5, 0, 0, 0), ins(ADDI, 5, 0, 0, 0), 0, 1, 0,
         ex(2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    step("fwd_split", 0, ins(R, 1, 5, 7, 0), ins(R, 7, 0, 0, 0), ins(ADDI, 5, 0, 0, 0), 1, 1, 0,
         ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step("fwd_r0", 0, ins(R, 1, 0, 0, 0), ins(R, 0, 0, 0, 0), ins(ADDI, 0, 0, 0, 0), 1, 1, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("fwd_nonwriter", 0, ins(R, 1, 5, 5, 0), ins(BNE, 5, 0, 0, 0), 0, 1, 0, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("ram_byp", 0, ins(R, 1, 3, 0, 0), ins(SW, 3, 0, 0, 0), ins(LW, 3, 0, 0, 0), 1, 1, 0,
         ex(2'b01, 2'b10, 1, 0, 0, 0, 0, 0));
    step("ram_mw_inval", 0, ins(R, 1, 3, 0, 0), ins(SW, 3, 0, 0, 0), ins(LW, 3, 0, 0, 0), 1, 0, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("ram_rd_diff", 0, ins(R, 1, 3, 0, 0), ins(SW, 3, 0, 0, 0), ins(LW, 4, 0, 0, 0), 1, 1, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    idle("idle0", 0, 0);

    // ---------------- load-use ----------------
    step("lu_rs_hit", ins(R, 2, 4, 1, 0), ins(LW, 4, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 1, 0, 1, 0, 0));
    step("lu_bubble", ins(R, 2, 4, 1, 0), 0, 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("lu_after", ins(R, 2, 4, 1, 0), 0, 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
`ifdef FWD_HAZARD_PERF_EN
    check_perf("after_loaduse");
`endif
    step("lu_rt_hit", ins(R, 2, 1, 4, 0), ins(LW, 4, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 1, 0, 1, 0, 0));
    step("lu_rt_bubble", ins(R, 2, 1, 4, 0), 0, 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("lu_rt_addi", ins(ADDI, 2, 1, 4, 0), ins(LW, 4, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("lu_rd_sw", ins(SW, 4, 1, 0, 0), ins(LW, 4, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 1, 0, 1, 0, 0));
    step("lu_sw_bubble", ins(SW, 4, 1, 0, 0), 0, 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("lu_rd_rtype", ins(R, 4, 1, 2, 0), ins(LW, 4, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step("lu_r0", ins(R, 2, 0, 0, 0), ins(LW, 0, 0, 0, 0), 0, 0, 0, 0, 0,
         ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));

    // ---------------- multdiv, ready on wait cycle 17 ----------------
    step("md_trig", 0, ins(R, 6, 1, 2, MUL), 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 17; i++)
      step($sformatf("md_wait%0d", i), 0, 0, 0, 0, 0, 0, (i == 17),
           ex(2'b10, 2'b10, 0, 1, 1, 0, (i == 1), 0));
    idle("md_done", 0, 0);
`ifdef FWD_HAZARD_PERF_EN
    check_perf("after_muldiv");
`endif

    // ---------------- ready coincides with the timeout limit ----------------
    step("md2_trig", 0, ins(R, 6, 1, 2, MUL), 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 40; i++)
      step($sformatf("md2_wait%0d", i), 0, 0, 0, 0, 0, 0, (i == 40),
           ex(2'b10, 2'b10, 0, 1, 1, 0, (i == 1), 0));
    idle("md2_done_noerr", 0, 0);

    // ---------------- timeout ----------------
    step("md3_trig", 0, ins(R, 6, 1, 2, DIV), 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 40; i++)
      step($sformatf("md3_wait%0d", i), 0, 0, 0, 0, 0, 0, 0,
           ex(2'b10, 2'b10, 0, 1, 1, 0, (i == 1), 0));
    idle("timeout_err", 0, 1);
    idle("rdy_in_idle", 1, 1);
    idle("err_sticky", 0, 1);

    // ---------------- async reset in the middle of MD_WAIT ----------------
    step("md4_trig", 0, ins(R, 6, 1, 2, MUL), 0, 0, 0, 0, 0, ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 1));
    bus.execute_instruction = '0;
    #1;
    sample("md4_pre_reset", ex(2'b10, 2'b10, 0, 1, 1, 0, 1, 1));
    reset_n = 1'b0;
    sample("mid_reset", ex(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
`ifdef FWD_HAZARD_PERF_EN
    exp_stall = 0;
    exp_hits  = 0;
    check_perf("mid_reset");
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    idle("post_reset", 0, 0);
    step("post_reset_fwd", 0, ins(R, 1, 9, 0, 0), ins(ADDI, 9, 0, 0, 0), 0, 1, 0, 0,
         ex(2'b00, 2'b10, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
